cla_seq_arb: RTL

Nibble-serial scheduler and two-port arbiter for the shared 4-bit carry-lookahead adder (`cla`) in the user project area. It accepts WIDTH-bit add requests from two requesters and grants them round-robin. It sequences the single 4-bit CLA over WIDTH/4 cycles, chaining the carry through a register, and returns the sum and carry-out on a valid/ready response channel. It sits between the requesters (IO/LA/Wishbone front ends) and the `cla` instance, which it drives exclusively.

---
 rtl/cla_seq_arb_pkg.sv | 17 +
 rtl/cla_seq_arb_if.sv | 43 ++++
 rtl/cla_seq_arb_rr_arb2.sv | 22 ++
 rtl/cla_seq_arb.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cla_seq_arb_pkg.sv
// Shared types and helpers for the nibble-serial CLA scheduler (cla_seq_arb).
package cla_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  // Number of CLA passes needed for a full-width operand.
  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla_seq_arb_if.sv
// Request/response channel bundle for cla_seq_arb.
// req_sub is present only when CLA_SEQ_SUB_EN is defined.
interface cla_seq_arb_if #(
  parameter int unsigned WIDTH = 16
);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         req_cin;
`ifdef CLA_SEQ_SUB_EN
  logic [1:0]         req_sub;
`endif
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_sum;
  logic               rsp_cout;

`ifdef CLA_SEQ_SUB_EN
  modport master (
    output req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
`endif

endinterface

// File: rtl/cla_seq_arb_rr_arb2.sv
// Two-input round-robin grant logic; the priority pointer itself lives in the caller.
// advance opens the arbitration window; with it low no grant is issued.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = pointer;
    if (!req[pointer]) begin
      gnt_id = ~pointer;
    end
    if (advance) begin
      gnt[gnt_id] = req[gnt_id];
    end
  end

endmodule

// File: rtl/cla_seq_arb.sv
// Two-requester scheduler driving one shared 4-bit CLA over WIDTH/4 cycles.
// Define CLA_SEQ_SUB_EN to add per-requester subtract (req_sub).
module cla_seq_arb
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  cla_seq_arb_if.slave        bus,
  output logic [NIBBLE_W-1:0] cla_a,
  output logic [NIBBLE_W-1:0] cla_b,
  output logic                cla_cin,
  input  logic [NIBBLE_W-1:0] cla_s,
  input  logic                cla_cout,
  output logic                busy
);

  localparam int unsigned Nib = nib_count(WIDTH);
  localparam int unsigned KW  = (Nib > 1) ? $clog2(Nib) : 1;
  localparam logic [KW-1:0] KLast = KW'(Nib - 1);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cin_q, cin_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;
  logic             op_sub;
  logic [1:0]       gnt;
  logic             gnt_id;
  logic [NIBBLE_W-1:0] b_nib;

`ifdef CLA_SEQ_SUB_EN
  logic sub_q, sub_d;
  assign op_sub = sub_q;
`else
  assign op_sub = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .req     (bus.req_valid),
    .pointer (ptr_q),
    .advance (state_q == StIdle),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // Subtraction is A + ~B + 1; the +1 is folded into the latched first carry-in.
  assign b_nib = op_sub ? ~b_q[NIBBLE_W*k_q +: NIBBLE_W] : b_q[NIBBLE_W*k_q +: NIBBLE_W];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef CLA_SEQ_SUB_EN
    sub_d   = sub_q;
`endif
    cla_a   = '0;
    cla_b   = '0;
    cla_cin = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          state_d = StAdd;
          k_d     = '0;
          a_d     = bus.req_a[gnt_id*WIDTH +: WIDTH];
          b_d     = bus.req_b[gnt_id*WIDTH +: WIDTH];
          cin_d   = bus.req_cin[gnt_id];
          id_d    = gnt_id;
          ptr_d   = ~gnt_id;
`ifdef CLA_SEQ_SUB_EN
          sub_d   = bus.req_sub[gnt_id];
          if (bus.req_sub[gnt_id]) begin
            cin_d = 1'b1;
          end
`endif
        end
      end

      StAdd: begin
        cla_a   = a_q[NIBBLE_W*k_q +: NIBBLE_W];
        cla_b   = b_nib;
        cla_cin = (k_q == '0) ? cin_q : carry_q;
        sum_d[NIBBLE_W*k_q +: NIBBLE_W] = cla_s;
        carry_d = cla_cout;
        k_d     = k_q + 1'b1;
        if (k_q == KLast) begin
          state_d = StDone;
          k_d     = '0;
        end
      end

      StDone: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef CLA_SEQ_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == StDone);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = carry_q;
  assign busy          = (state_q != StIdle);

endmodule
